// File: rtl/corelet_pkg.sv
// Shared state encoding and instruction-field layout for the corelet sequencer.
package corelet_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_LOAD,
        W_KERNEL,
        X_LOAD,
        X_EXEC,
        DRAIN,
        DONE
    } state_t;

    localparam int INST_W   = 35;
    localparam int MAC_LO   = 0;
    localparam int L0_WR    = 2;
    localparam int L0_RD    = 3;
    localparam int OFIFO_RD = 6;
    localparam int SFP_ACC  = 33;
    localparam int MODE     = 34;

    localparam logic [1:0] MAC_NOP  = 2'b00;
    localparam logic [1:0] MAC_LOAD = 2'b01;
    localparam logic [1:0] MAC_EXEC = 2'b10;

    // Bits needed to count up to and including max(a, b).
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/corelet_ctrl_xmem_loader.sv
// Issues a run of xmem reads and the matching L0 writes one cycle later,
// holding the read data and stalling issue while L0 reports full.
module xmem_loader #(
    parameter int aw = 11,
    parameter int nw = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic [aw-1:0] base,
    input  logic [nw-1:0] num,
    input  logic          l0_full,
    output logic          cen,
    output logic [aw-1:0] addr,
    output logic          l0_wr,
    output logic          last,
    output logic          stall
);

    logic [nw-1:0] cnt;
    logic [nw-1:0] num_q;
    logic [aw-1:0] base_q;
    logic          rd_d;
    logic          held;
    logic          pend;

    // A write is owed for a read issued this cycle or one parked by a stall.
    // l0_full seen at an edge blocks the write that edge would launch.
    assign pend  = ~cen | held;
    assign stall = pend & l0_full;
    assign last  = rd_d & cen & ~held & (cnt == num_q);
    assign l0_wr = rd_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cen    <= 1'b1;
            addr   <= '0;
            rd_d   <= 1'b0;
            held   <= 1'b0;
            cnt    <= '0;
            num_q  <= '0;
            base_q <= '0;
        end else if (go) begin
            cen    <= 1'b0;
            addr   <= base;
            base_q <= base;
            num_q  <= num;
            cnt    <= nw'(1);
            rd_d   <= 1'b0;
            held   <= 1'b0;
        end else if (stall) begin
            // SRAM output holds while cen stays high, so the data survives.
            cen  <= 1'b1;
            rd_d <= 1'b0;
            held <= 1'b1;
        end else begin
            rd_d <= pend;
            held <= 1'b0;
            if (cnt != num_q) begin
                cen  <= 1'b0;
                addr <= base_q + aw'(cnt);
                cnt  <= cnt + nw'(1);
            end else begin
                cen <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/corelet_ctrl.sv
// Layer sequencer: per kernel position loads weights, streams activations,
// executes the MAC array and drains the OFIFO into pmem.
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int len_kij  = 9,
    parameter int len_nij  = 36,
    parameter int xaddr_bw = 11,
    parameter int paddr_bw = 11,
    parameter logic [xaddr_bw-1:0] w_base = xaddr_bw'(1024)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode_sel,
    input  logic                l0_full,
    input  logic                ofifo_valid,
    output logic [INST_W-1:0]   inst,
    output logic                xmem_cen,
    output logic                xmem_wen,
    output logic [xaddr_bw-1:0] xmem_addr,
    output logic                pmem_cen,
    output logic                pmem_wen,
    output logic [paddr_bw-1:0] pmem_addr,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int CW = cnt_width(row + col, len_nij);
    localparam int KW = cnt_width(len_kij, 1);

    state_t              state;
    logic [KW-1:0]       kij;
    logic [CW-1:0]       cnt;
    logic                mode_q;
    logic [1:0]          mac;
    logic                l0_rd;
    logic                ofifo_rd;
    logic [xaddr_bw-1:0] wptr;
    logic [paddr_bw-1:0] pptr;

    logic                start_ok, kern_end, drain_end, more_k;
    logic                ld_go, go_w, ld_wr, ld_last, ld_stall;
    logic [xaddr_bw-1:0] ld_base;
    logic [CW-1:0]       ld_n;

    assign start_ok  = (state == IDLE) && start;
    assign kern_end  = (state == W_KERNEL) && (cnt == CW'(row + col - 1));
    assign drain_end = (state == DRAIN) && ofifo_rd && (cnt == CW'(len_nij));
    assign more_k    = (kij != KW'(len_kij - 1));

    // Loads launch on the same edge as the state change so the first read
    // lands in the first cycle of W_LOAD / X_LOAD.
    assign ld_go   = start_ok | kern_end | (drain_end & more_k);
    assign go_w    = start_ok ? ~mode_sel : (drain_end & ~mode_q);
    assign ld_base = !go_w    ? '0 :
                     start_ok ? w_base : wptr + xaddr_bw'(row);
    assign ld_n    = go_w ? CW'(row) : CW'(len_nij);

    xmem_loader #(.aw(xaddr_bw), .nw(CW)) u_loader (
        .clk    (clk),
        .reset  (reset),
        .go     (ld_go),
        .base   (ld_base),
        .num    (ld_n),
        .l0_full(l0_full),
        .cen    (xmem_cen),
        .addr   (xmem_addr),
        .l0_wr  (ld_wr),
        .last   (ld_last),
        .stall  (ld_stall)
    );

    assign xmem_wen = 1'b1;

    always_comb begin
        inst               = '0;
        inst[MAC_LO +: 2]  = mac;
        inst[L0_WR]        = ld_wr;
        inst[L0_RD]        = l0_rd;
        inst[OFIFO_RD]     = ofifo_rd;
        inst[SFP_ACC]      = 1'b0;
        inst[MODE]         = mode_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            kij       <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            mac       <= MAC_NOP;
            l0_rd     <= 1'b0;
            ofifo_rd  <= 1'b0;
            pmem_cen  <= 1'b1;
            pmem_wen  <= 1'b1;
            pmem_addr <= '0;
            pptr      <= '0;
            wptr      <= w_base;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ld_stall) err <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    mode_q <= mode_sel;
                    err    <= 1'b0;
                    busy   <= 1'b1;
                    kij    <= '0;
                    cnt    <= '0;
                    pptr   <= '0;
                    wptr   <= w_base;
                    state  <= mode_sel ? X_LOAD : W_LOAD;
                end
                W_LOAD: if (ld_last) begin
                    state <= W_KERNEL;
                    mac   <= MAC_LOAD;
                    l0_rd <= 1'b1;
                    cnt   <= '0;
                end
                W_KERNEL: if (kern_end) begin
                    state <= X_LOAD;
                    mac   <= MAC_NOP;
                    l0_rd <= 1'b0;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                X_LOAD: if (ld_last) begin
                    state <= X_EXEC;
                    mac   <= MAC_EXEC;
                    l0_rd <= 1'b1;
                    cnt   <= '0;
                end
                X_EXEC: if (cnt == CW'(len_nij - 1)) begin
                    state <= DRAIN;
                    mac   <= MAC_NOP;
                    l0_rd <= 1'b0;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                DRAIN: begin
                    if (drain_end) begin
                        ofifo_rd <= 1'b0;
                        pmem_cen <= 1'b1;
                        pmem_wen <= 1'b1;
                        cnt      <= '0;
                        if (more_k) begin
                            kij   <= kij + KW'(1);
                            state <= mode_q ? X_LOAD : W_LOAD;
                            if (!mode_q) wptr <= wptr + xaddr_bw'(row);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    // Skip the cycle after a pop: valid seen then may still
                    // describe the word being popped.
                    end else if (ofifo_valid && !ofifo_rd) begin
                        ofifo_rd  <= 1'b1;
                        pmem_cen  <= 1'b0;
                        pmem_wen  <= 1'b0;
                        pmem_addr <= pptr;
                        pptr      <= pptr + paddr_bw'(1);
                        cnt       <= cnt + CW'(1);
                    end else begin
                        ofifo_rd <= 1'b0;
                        pmem_cen <= 1'b1;
                        pmem_wen <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
